i2s_rx: RTL and testbench

- I2S slave receiver: the input-side counterpart of the board's I2S transmit pins (I2Sx_SCK/WS/SDA).
- Oversamples externally clocked SCK/WS/SDA in the system clock domain.
- Deserialises Philips-format I2S, MSB first, one-SCK delay after WS.
- Presents one channel-tagged sample at a time to the mixer core over a valid/ack handshake.

---
 rtl/dmix_audio_pkg.sv | 18 +
 rtl/sync_ff.sv | 26 ++
 rtl/i2s_rx.sv | 138 +++++++++++++
 tb/tb_i2s_rx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmix_audio_pkg.sv
// Shared audio definitions for the mixer front-end receivers.
// Holds the default sample width and the channel encoding.
// Combinational helpers only; no state lives here.
package dmix_audio_pkg;

  // Default captured sample width for all audio receivers
  localparam int SAMPLE_W = 24;

  // Channel tags carried alongside each sample
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Width of a saturating bit counter that must reach the value w
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser for signals arriving from another clock domain.
// Latency: STAGES clk cycles from input change to q.
// No backpressure; the input is sampled every cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S slave receiver delivering channel-tagged samples to the mixer.
// Latency: valid_o rises SYNC_STAGES+2 clk cycles after sck_i is first sampled high on a WS boundary rise.
// Backpressure: one held sample; a word completing while it is untaken is dropped and flagged on overflow_o.
module i2s_rx
  import dmix_audio_pkg::*;
#(
  parameter int DATA_W      = SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sda_i,
  output logic [DATA_W-1:0] data_o,
  output logic              lrck_o,
  output logic              valid_o,
  input  logic              ack_i,
  output logic              overflow_o,
  output logic              locked_o
);

  localparam int CW = cnt_w(DATA_W);

  // Synchronised copies of the I2S pins
  logic sck_s;
  logic ws_s;
  logic sda_s;

  // Edge detect and the sample taken on each SCK rise
  logic sck_s_d;
  logic rise;
  logic smp_vld;
  logic smp_bit;
  logic smp_ws;

  // Deserialiser state
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              ws_q;
  logic [CW-1:0]     cnt_ins;
  logic [DATA_W-1:0] shreg_ins;
  logic              boundary;

  // Completed word waiting for the output register
  logic              done_q;
  logic [DATA_W-1:0] done_dat;
  logic              done_ch;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst(rst), .d(sck_i), .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ws  (.clk(clk), .rst(rst), .d(ws_i),  .q(ws_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sda (.clk(clk), .rst(rst), .d(sda_i), .q(sda_s));

  assign rise     = sck_s & ~sck_s_d;
  assign boundary = smp_vld & (smp_ws != ws_q);

  // Capture SDA and WS on every detected SCK rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s_d <= 1'b0;
      smp_vld <= 1'b0;
      smp_bit <= 1'b0;
      smp_ws  <= CH_LEFT;
    end else begin
      sck_s_d <= sck_s;
      smp_vld <= rise;
      if (rise) begin
        smp_bit <= sda_s;
        smp_ws  <= ws_s;
      end
    end
  end

  // Place the sampled bit MSB-first; bits past DATA_W are dropped and cnt saturates
  always_comb begin
    shreg_ins = shreg;
    cnt_ins   = cnt;
    if (cnt < CW'(DATA_W)) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (cnt == CW'(DATA_W - 1 - i)) begin
          shreg_ins[i] = smp_bit;
        end
      end
      cnt_ins = cnt + 1'b1;
    end
  end

  // Deserialise; a WS change closes the word of the previous channel including this bit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      shreg    <= '0;
      ws_q     <= CH_LEFT;
      locked_o <= 1'b0;
      done_q   <= 1'b0;
      done_dat <= '0;
      done_ch  <= CH_LEFT;
    end else begin
      done_q <= 1'b0;
      if (boundary) begin
        done_q   <= locked_o;
        done_dat <= shreg_ins;
        done_ch  <= ws_q;
        cnt      <= '0;
        shreg    <= '0;
        ws_q     <= smp_ws;
        locked_o <= 1'b1;
      end else if (smp_vld) begin
        cnt   <= cnt_ins;
        shreg <= shreg_ins;
      end
    end
  end

  // Output holding register with valid/ack handshake and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o     <= '0;
      lrck_o     <= CH_LEFT;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (done_q) begin
        if (!valid_o || ack_i) begin
          data_o  <= done_dat;
          lrck_o  <= done_ch;
          valid_o <= 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end else if (valid_o && ack_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: random I2S slot streams against a slot-level model.
// Two instances (SYNC_STAGES 2 and 3) share the pins to check both latencies.
// Expected words come from slot contents, never from the DUT.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck_i = 1'b0;
  logic        ws_i = 1'b0;
  logic        sda_i = 1'b0;
  logic        ack_i = 1'b0;
  logic [23:0] data_o;
  logic        lrck_o, valid_o, overflow_o, locked_o;
  logic [23:0] data3;
  logic        lrck3, valid3, ov3, locked3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ch;
    int          len;
    logic [31:0] val;
  } slot_t;

  slot_t       slots[$];
  logic        rise_ws[$];
  logic        rise_bit[$];
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  int          ov_cnt;
  int          unstable;

  i2s_rx #(.DATA_W(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i), .sda_i(sda_i),
    .data_o(data_o), .lrck_o(lrck_o), .valid_o(valid_o), .ack_i(ack_i),
    .overflow_o(overflow_o), .locked_o(locked_o)
  );

  i2s_rx #(.DATA_W(24), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i), .sda_i(sda_i),
    .data_o(data3), .lrck_o(lrck3), .valid_o(valid3), .ack_i(ack_i),
    .overflow_o(ov3), .locked_o(locked3)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Top DATA_W bits of a len-bit MSB-first slot, zero-filled when the slot is short
  function automatic logic [23:0] word_of(input logic [31:0] v, input int len);
    logic [55:0] t;
    t = {v, 24'h0};
    return t[len+23 -: 24];
  endfunction

  task automatic add_slot(input logic ch, input int len, input logic [31:0] v);
    slot_t s;
    logic [63:0] m;
    m = (64'd1 << len) - 64'd1;
    s.ch = ch;
    s.len = len;
    s.val = v & m[31:0];
    slots.push_back(s);
  endtask

  // Expand slots to per-rise (ws, bit); WS leads the data by one SCK
  task automatic build_stream();
    logic bitch[$];
    rise_ws.delete();
    rise_bit.delete();
    exp_q.delete();
    got_q.delete();
    ov_cnt = 0;
    unstable = 0;
    foreach (slots[i]) begin
      for (int b = slots[i].len - 1; b >= 0; b--) begin
        bitch.push_back(slots[i].ch);
        rise_bit.push_back(slots[i].val[b]);
      end
    end
    for (int k = 0; k < bitch.size(); k++) begin
      rise_ws.push_back((k + 1 < bitch.size()) ? bitch[k+1] : bitch[k]);
    end
    for (int i = 1; i < slots.size() - 1; i++) begin
      exp_q.push_back({slots[i].ch, word_of(slots[i].val, slots[i].len)});
    end
  endtask

  task automatic sck_fall(input logic ws, input logic b, input int half);
    @(negedge clk);
    sck_i = 1'b0;
    ws_i  = ws;
    sda_i = b;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic sck_rise(input int half);
    @(negedge clk);
    sck_i = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  // Drive rises from..to while logging taken samples, overflow cycles and held-data changes
  task automatic run_stream(input int from, input int to, input int half);
    bit drv_done;
    drv_done = 1'b0;
    fork
      begin
        for (int k = from; k <= to; k++) begin
          sck_fall(rise_ws[k], rise_bit[k], half);
          sck_rise(half);
        end
        sck_fall(rise_ws[to], 1'b0, half);
        drv_done = 1'b1;
      end
      begin
        int          tail;
        logic        pv, pa;
        logic [24:0] pd;
        tail = 0; pv = 1'b0; pa = 1'b0; pd = '0;
        while (tail < 24) begin
          @(negedge clk);
          if (valid_o && ack_i) got_q.push_back({lrck_o, data_o});
          if (overflow_o) ov_cnt++;
          if (valid_o && pv && !pa && ({lrck_o, data_o} != pd)) unstable++;
          pv = valid_o;
          pa = ack_i;
          pd = {lrck_o, data_o};
          if (drv_done) tail++;
        end
      end
    join
  endtask

  task automatic do_reset();
    @(negedge clk);
    sck_i = 1'b0; ws_i = 1'b0; sda_i = 1'b0; ack_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    slots.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (data_o !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    total++; if (lrck_o !== 1'b0) begin bad++; $display("FAIL reset_lrck got=%b exp=0", lrck_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked_o); end
    total++; if ({data3, lrck3, valid3, ov3, locked3} !== 28'h0) begin
      bad++; $display("FAIL reset_dut3 got=%h exp=0", {data3, lrck3, valid3, ov3, locked3});
    end
  endtask

  task automatic test_lock_first_word();
    int last;
    do_reset();
    ack_i = 1'b1;
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 32, 32'hABCDEF00 | $urandom_range(255));
      add_slot(1'b1, 32, 32'h12345600 | $urandom_range(255));
    end
    build_stream();
    last = rise_bit.size() - 1;
    run_stream(0, 30, 4);
    total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL lock_before_edge got=%b exp=0", locked_o); end
    run_stream(31, last, 4);
    total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL lock_after_edge got=%b exp=1", locked_o); end
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL lock_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL lock_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (ov_cnt != 0) begin bad++; $display("FAIL lock_overflow got=%0d exp=0", ov_cnt); end
    ack_i = 1'b0;
  endtask

  task automatic test_short_slot();
    do_reset();
    ack_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 16, 32'hBEEF);
      add_slot(1'b1, 16, $urandom);
    end
    build_stream();
    run_stream(0, rise_bit.size() - 1, $urandom_range(5, 2));
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL short_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL short_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (got_q.size() > 1 && got_q[1] !== {1'b0, 24'hBEEF00}) begin
      bad++; $display("FAIL short_left got=%h exp=%h", got_q[1], {1'b0, 24'hBEEF00});
    end
    ack_i = 1'b0;
  endtask

  task automatic test_random_slots();
    do_reset();
    ack_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) add_slot(1'b0, $urandom_range(32, 2), $urandom);
      else if (i == 3) add_slot(1'b1, 1, 32'h1);
      else add_slot(i[0], $urandom_range(32, 1), $urandom);
    end
    build_stream();
    run_stream(0, rise_bit.size() - 1, $urandom_range(5, 2));
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (ov_cnt != 0) begin bad++; $display("FAIL random_overflow got=%0d exp=0", ov_cnt); end
    ack_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [24:0] first;
    do_reset();
    ack_i = 1'b0;
    add_slot(1'b0, 24, $urandom);
    add_slot(1'b1, 24, $urandom);
    add_slot(1'b0, 20, $urandom);
    add_slot(1'b1, 8, $urandom);
    build_stream();
    first = exp_q[0];
    run_stream(0, rise_bit.size() - 1, 3);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", valid_o); end
    total++; if ({lrck_o, data_o} !== first) begin bad++; $display("FAIL bp_held got=%h exp=%h", {lrck_o, data_o}, first); end
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL bp_overflow_cycles got=%0d exp=1", ov_cnt); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable changes=%0d exp=0", unstable); end
    @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_valid_fall got=%b exp=0", valid_o); end
  endtask

  task automatic test_ack_coincide();
    do_reset();
    ack_i = 1'b0;
    for (int i = 0; i < 4; i++) add_slot(i[0], 8, $urandom);
    build_stream();
    run_stream(0, 22, 4);
    total++; if ({valid_o, lrck_o, data_o} !== {1'b1, exp_q[0]}) begin
      bad++; $display("FAIL coin_pre got=%h exp=%h", {valid_o, lrck_o, data_o}, {1'b1, exp_q[0]});
    end
    sck_fall(rise_ws[23], rise_bit[23], 4);
    @(negedge clk);
    sck_i = 1'b1;
    repeat (4) @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL coin_valid got=%b exp=1", valid_o); end
    total++; if ({lrck_o, data_o} !== exp_q[1]) begin bad++; $display("FAIL coin_data got=%h exp=%h", {lrck_o, data_o}, exp_q[1]); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL coin_overflow got=%b exp=0", overflow_o); end
  endtask

  task automatic test_latency();
    int lat2, lat3;
    logic [24:0] d2, d3;
    do_reset();
    ack_i = 1'b1;
    for (int i = 0; i < 3; i++) add_slot(i[0], 8, $urandom);
    build_stream();
    run_stream(0, 14, 3);
    sck_fall(rise_ws[15], rise_bit[15], 3);
    @(negedge clk);
    sck_i = 1'b1;
    lat2 = -1; lat3 = -1; d2 = '0; d3 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (valid_o && lat2 < 0) begin lat2 = k - 1; d2 = {lrck_o, data_o}; end
      if (valid3 && lat3 < 0) begin lat3 = k - 1; d3 = {lrck3, data3}; end
    end
    total++; if (lat2 != 4) begin bad++; $display("FAIL latency_sync2 got=%0d exp=4", lat2); end
    total++; if (lat3 != 5) begin bad++; $display("FAIL latency_sync3 got=%0d exp=5", lat3); end
    total++; if (d2 !== exp_q[0]) begin bad++; $display("FAIL latency_data2 got=%h exp=%h", d2, exp_q[0]); end
    total++; if (d3 !== exp_q[0]) begin bad++; $display("FAIL latency_data3 got=%h exp=%h", d3, exp_q[0]); end
    ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [24:0] r1, r3, l4;
    do_reset();
    ack_i = 1'b1;
    for (int i = 0; i < 6; i++) add_slot(i[0], 24, $urandom);
    build_stream();
    r1 = exp_q[0];
    r3 = exp_q[2];
    l4 = exp_q[3];
    run_stream(0, 57, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({data_o, lrck_o, valid_o, overflow_o, locked_o} !== 28'h0) begin
      bad++; $display("FAIL midrst_outputs got=%h exp=0", {data_o, lrck_o, valid_o, overflow_o, locked_o});
    end
    run_stream(58, rise_bit.size() - 1, 3);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL midrst_count got=%0d exp=3", got_q.size()); end
    if (got_q.size() == 3) begin
      total++; if (got_q[0] !== r1) begin bad++; $display("FAIL midrst_w0 got=%h exp=%h", got_q[0], r1); end
      total++; if (got_q[1] !== r3) begin bad++; $display("FAIL midrst_w1 got=%h exp=%h", got_q[1], r3); end
      total++; if (got_q[2] !== l4) begin bad++; $display("FAIL midrst_w2 got=%h exp=%h", got_q[2], l4); end
    end
    total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL midrst_relock got=%b exp=1", locked_o); end
    ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_first_word();
    test_short_slot();
    test_random_slots();
    test_backpressure();
    test_ack_coincide();
    test_latency();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
